// File: rtl/gate_vector_checker.sv
// Exhaustive sweep checker for a NAND gate family.
// Drives every input vector 0 .. 2^WIDTH-1 to three gate instances (_E, _C, _SC).
// After each vector settles, it compares their outputs with a golden NAND and
// accumulates error statistics. One sweep runs per accepted start.
module gate_vector_checker #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] vec,
  input  logic             obs_e,
  input  logic             obs_c,
  input  logic             obs_sc,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [5:0]       err_cnt,
  output logic [2:0]       fail_mask,
  output logic [WIDTH-1:0] first_fail_vec,
  output logic             first_fail_valid
);

  typedef enum logic [2:0] {StIdle, StDrive, StWait, StCheck, StDone} state_e;

  localparam logic [WIDTH-1:0] VecLast  = {WIDTH{1'b1}};
  // Last WAIT count value; unused when SETTLE is 0 because WAIT is skipped.
  localparam logic [2:0]       WaitLast = (SETTLE > 0) ? 3'(SETTLE - 1) : 3'd0;
  localparam logic [5:0]       ErrMax   = 6'd32;

  state_e     state;
  logic [2:0] wait_cnt;

  logic       golden;
  logic [2:0] mismatch;
  logic       any_mismatch;
  logic [5:0] err_next;

  // Golden NAND and mismatch vector for the vector currently driven.
  always_comb begin
    golden       = ~(&vec);
    mismatch     = {obs_sc, obs_c, obs_e} ^ {3{golden}};
    any_mismatch = |mismatch;
    err_next     = err_cnt;
    if (any_mismatch && (err_cnt != ErrMax)) begin
      err_next = err_cnt + 6'd1;
    end
  end

  // Sweep sequencer; every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= StIdle;
      wait_cnt         <= 3'd0;
      vec              <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_cnt          <= 6'd0;
      fail_mask        <= 3'd0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            state            <= StDrive;
            wait_cnt         <= 3'd0;
            vec              <= '0;
            busy             <= 1'b1;
            pass             <= 1'b0;
            err_cnt          <= 6'd0;
            fail_mask        <= 3'd0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
          end
        end

        StDrive: begin
          wait_cnt <= 3'd0;
          if (SETTLE > 0) begin
            state <= StWait;
          end else begin
            state <= StCheck;
          end
        end

        StWait: begin
          if (wait_cnt == WaitLast) begin
            wait_cnt <= 3'd0;
            state    <= StCheck;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end

        StCheck: begin
          err_cnt   <= err_next;
          fail_mask <= fail_mask | mismatch;
          if (any_mismatch && !first_fail_valid) begin
            first_fail_vec   <= vec;
            first_fail_valid <= 1'b1;
          end
          // Stop at the all-ones vector so the counter never wraps mid-sweep.
          if (vec == VecLast) begin
            state <= StDone;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 6'd0);
          end else begin
            vec   <= vec + WIDTH'(1);
            state <= StDrive;
          end
        end

        StDone: begin
          done  <= 1'b0;
          state <= StIdle;
        end

        default: begin
          state <= StIdle;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench for gate_vector_checker: three instances (5/1, 3/1, 2/0 for
// WIDTH/SETTLE) fed by behavioural NAND models with selectable faults.
module tb_gate_vector_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Fault modes: 0 good, 1 inverted, 2 stuck-0, 3 stuck-1, 4 inverted on vec 3 and 5.
  logic [2:0] me[3];
  logic [2:0] mc[3];
  logic [2:0] ms[3];

  function automatic logic model(input logic [2:0] m, input logic g, input logic [4:0] v);
    case (m)
      3'd0:    model = g;
      3'd1:    model = ~g;
      3'd2:    model = 1'b0;
      3'd3:    model = 1'b1;
      3'd4:    model = (v == 5'd3 || v == 5'd5) ? ~g : g;
      default: model = g;
    endcase
  endfunction

  // WIDTH=5, SETTLE=1
  logic st5, bz5, dn5, ps5, fv5, oe5, oc5, os5;
  logic [4:0] v5, ff5;
  logic [5:0] ec5;
  logic [2:0] fm5;
  assign oe5 = model(me[0], ~(&v5), v5);
  assign oc5 = model(mc[0], ~(&v5), v5);
  assign os5 = model(ms[0], ~(&v5), v5);
  gate_vector_checker #(.WIDTH(5), .SETTLE(1)) u5 (
    .clk(clk), .rst(rst), .start(st5), .vec(v5), .obs_e(oe5), .obs_c(oc5), .obs_sc(os5),
    .busy(bz5), .done(dn5), .pass(ps5), .err_cnt(ec5), .fail_mask(fm5),
    .first_fail_vec(ff5), .first_fail_valid(fv5)
  );

  // WIDTH=3, SETTLE=1
  logic st3, bz3, dn3, ps3, fv3, oe3, oc3, os3;
  logic [2:0] v3, ff3;
  logic [5:0] ec3;
  logic [2:0] fm3;
  assign oe3 = model(me[1], ~(&v3), 5'(v3));
  assign oc3 = model(mc[1], ~(&v3), 5'(v3));
  assign os3 = model(ms[1], ~(&v3), 5'(v3));
  gate_vector_checker #(.WIDTH(3), .SETTLE(1)) u3 (
    .clk(clk), .rst(rst), .start(st3), .vec(v3), .obs_e(oe3), .obs_c(oc3), .obs_sc(os3),
    .busy(bz3), .done(dn3), .pass(ps3), .err_cnt(ec3), .fail_mask(fm3),
    .first_fail_vec(ff3), .first_fail_valid(fv3)
  );

  // WIDTH=2, SETTLE=0
  logic st2, bz2, dn2, ps2, fv2, oe2, oc2, os2;
  logic [1:0] v2, ff2;
  logic [5:0] ec2;
  logic [2:0] fm2;
  assign oe2 = model(me[2], ~(&v2), 5'(v2));
  assign oc2 = model(mc[2], ~(&v2), 5'(v2));
  assign os2 = model(ms[2], ~(&v2), 5'(v2));
  gate_vector_checker #(.WIDTH(2), .SETTLE(0)) u2 (
    .clk(clk), .rst(rst), .start(st2), .vec(v2), .obs_e(oe2), .obs_c(oc2), .obs_sc(os2),
    .busy(bz2), .done(dn2), .pass(ps2), .err_cnt(ec2), .fail_mask(fm2),
    .first_fail_vec(ff2), .first_fail_valid(fv2)
  );

  // Selected-instance view.
  int sel = 0;
  logic       s_busy, s_done, s_pass, s_ffvalid;
  logic [4:0] s_vec, s_ffv;
  logic [5:0] s_err;
  logic [2:0] s_mask;
  always_comb begin
    s_busy = bz5; s_done = dn5; s_pass = ps5; s_ffvalid = fv5;
    s_vec = v5; s_ffv = ff5; s_err = ec5; s_mask = fm5;
    if (sel == 1) begin
      s_busy = bz3; s_done = dn3; s_pass = ps3; s_ffvalid = fv3;
      s_vec = 5'(v3); s_ffv = 5'(ff3); s_err = ec3; s_mask = fm3;
    end else if (sel == 2) begin
      s_busy = bz2; s_done = dn2; s_pass = ps2; s_ffvalid = fv2;
      s_vec = 5'(v2); s_ffv = 5'(ff2); s_err = ec2; s_mask = fm2;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_start(input int d, input logic b);
    if (d == 0) st5 = b;
    else if (d == 1) st3 = b;
    else st2 = b;
  endtask

  // Cycle 1 is the first cycle after the accepting edge; returns the cycle showing done.
  task automatic sweep(input int d, output int cyc, output int busy_cycles);
    bit to;
    @(negedge clk);
    set_start(d, 1'b1);
    @(posedge clk);
    #1 set_start(d, 1'b0);
    cyc = 0;
    busy_cycles = 0;
    to = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      cyc++;
      if (s_busy) busy_cycles++;
      if (s_done) begin
        to = 1'b0;
        break;
      end
    end
    if (to) begin
      checks++;
      failures++;
      $display("FAIL sweep_timeout actual=no_done required=done");
    end
  endtask

  typedef struct {
    int         dut;
    logic [2:0] fe, fc, fs;
    logic [5:0] err;
    logic [2:0] mask;
    logic [4:0] ffv;
    logic       ffvalid;
    logic       pass;
    int         cyc;
  } vec_t;

  vec_t tbl[7];
  int cyc, bcyc;
  bit hit;

  initial begin
    tbl[0] = '{0, 3'd0, 3'd0, 3'd0, 6'd0,  3'b000, 5'd0,  1'b0, 1'b1, 97};
    tbl[1] = '{0, 3'd0, 3'd3, 3'd0, 6'd1,  3'b010, 5'd31, 1'b1, 1'b0, 97};
    tbl[2] = '{1, 3'd0, 3'd0, 3'd1, 6'd8,  3'b100, 5'd0,  1'b1, 1'b0, 25};
    tbl[3] = '{2, 3'd0, 3'd0, 3'd0, 6'd0,  3'b000, 5'd0,  1'b0, 1'b1, 9};
    tbl[4] = '{0, 3'd1, 3'd0, 3'd0, 6'd32, 3'b001, 5'd0,  1'b1, 1'b0, 97};
    tbl[5] = '{1, 3'd2, 3'd0, 3'd0, 6'd7,  3'b001, 5'd0,  1'b1, 1'b0, 25};
    tbl[6] = '{2, 3'd3, 3'd3, 3'd3, 6'd1,  3'b111, 5'd3,  1'b1, 1'b0, 9};

    for (int i = 0; i < 3; i++) begin
      me[i] = 3'd0; mc[i] = 3'd0; ms[i] = 3'd0;
    end
    st5 = 1'b0; st3 = 1'b0; st2 = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_vec", 32'(v5), 32'd0);
    check("rst_busy", 32'({bz5, bz3, bz2}), 32'd0);
    check("rst_done", 32'({dn5, dn3, dn2}), 32'd0);
    check("rst_pass", 32'(ps5), 32'd0);
    check("rst_err", 32'(ec5), 32'd0);
    check("rst_ffvalid", 32'(fv5), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      sel = tbl[i].dut;
      me[sel] = tbl[i].fe; mc[sel] = tbl[i].fc; ms[sel] = tbl[i].fs;
      sweep(sel, cyc, bcyc);
      check($sformatf("t%0d_done_cycle", i), 32'(cyc), 32'(tbl[i].cyc));
      check($sformatf("t%0d_busy_cycles", i), 32'(bcyc), 32'(tbl[i].cyc - 1));
      check($sformatf("t%0d_busy_in_done", i), 32'(s_busy), 32'd0);
      check($sformatf("t%0d_err_cnt", i), 32'(s_err), 32'(tbl[i].err));
      check($sformatf("t%0d_fail_mask", i), 32'(s_mask), 32'(tbl[i].mask));
      check($sformatf("t%0d_ffvalid", i), 32'(s_ffvalid), 32'(tbl[i].ffvalid));
      check($sformatf("t%0d_ffvec", i), 32'(s_ffv), 32'(tbl[i].ffv));
      check($sformatf("t%0d_pass", i), 32'(s_pass), 32'(tbl[i].pass));
      check($sformatf("t%0d_last_vec", i), 32'(s_vec), 32'((1 << (5 - 2 * sel + (sel == 2 ? 1 : 0))) - 1));
      @(negedge clk);
      check($sformatf("t%0d_done_pulse", i), 32'(s_done), 32'd0);
      check($sformatf("t%0d_pass_held", i), 32'(s_pass), 32'(tbl[i].pass));
      me[sel] = 3'd0; mc[sel] = 3'd0; ms[sel] = 3'd0;
    end

    // Reset mid-sweep with partial results: faults at vec 3 and 5 give err_cnt=2 at vec 10.
    sel = 0;
    me[0] = 3'd4;
    @(negedge clk);
    st5 = 1'b1;
    @(posedge clk);
    #1 st5 = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_vec == 5'd10) begin
        hit = 1'b1;
        break;
      end
    end
    check("mid_reached_vec10", 32'(hit), 32'd1);
    check("mid_err_cnt", 32'(s_err), 32'd2);
    check("mid_ffvec", 32'(s_ffv), 32'd3);
    check("mid_mask", 32'(s_mask), 32'b001);
    check("mid_busy", 32'(s_busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_vec", 32'(s_vec), 32'd0);
    check("async_busy", 32'(s_busy), 32'd0);
    check("async_done", 32'(s_done), 32'd0);
    check("async_pass", 32'(s_pass), 32'd0);
    check("async_err", 32'(s_err), 32'd0);
    check("async_mask", 32'(s_mask), 32'd0);
    check("async_ffvec", 32'(s_ffv), 32'd0);
    check("async_ffvalid", 32'(s_ffvalid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    me[0] = 3'd0;
    sweep(0, cyc, bcyc);
    check("post_rst_done_cycle", 32'(cyc), 32'd97);
    check("post_rst_busy_cycles", 32'(bcyc), 32'd96);
    check("post_rst_err", 32'(s_err), 32'd0);
    check("post_rst_ffvalid", 32'(s_ffvalid), 32'd0);
    check("post_rst_pass", 32'(s_pass), 32'd1);

    // start held high: no restart until IDLE, then a fresh sweep with pass cleared.
    sel = 2;
    @(negedge clk);
    st2 = 1'b1;
    @(posedge clk);
    cyc = 0;
    bcyc = 0;
    hit = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      cyc++;
      if (s_busy) bcyc++;
      if (s_done) begin
        hit = 1'b1;
        break;
      end
    end
    check("hold_done_seen", 32'(hit), 32'd1);
    check("hold_done_cycle", 32'(cyc), 32'd9);
    check("hold_busy_cycles", 32'(bcyc), 32'd8);
    @(negedge clk);
    check("hold_idle_busy", 32'(s_busy), 32'd0);
    check("hold_idle_done", 32'(s_done), 32'd0);
    check("hold_idle_pass", 32'(s_pass), 32'd1);
    @(negedge clk);
    check("hold_restart_busy", 32'(s_busy), 32'd1);
    check("hold_restart_pass", 32'(s_pass), 32'd0);
    check("hold_restart_vec", 32'(s_vec), 32'd0);
    st2 = 1'b0;
    cyc = 1;
    hit = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      cyc++;
      if (s_done) begin
        hit = 1'b1;
        break;
      end
    end
    check("hold2_done_seen", 32'(hit), 32'd1);
    check("hold2_done_cycle", 32'(cyc), 32'd9);
    check("hold2_pass", 32'(s_pass), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
